// File: rtl/periph_bus_master.sv
// periph_bus_master: scripted initiator for the 8-bit-address peripheral register bus.
// One command in, one response out; read, write and poll-until-match with timeout.
module periph_bus_master #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int POLL_MAX       = 1024,
   parameter int POLL_GAP       = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_cmd_valid,
   output logic        o_cmd_ready,
   input  logic [1:0]  i_cmd_op,
   input  logic [7:0]  i_cmd_addr,
   input  logic [31:0] i_cmd_wdata,
   input  logic [31:0] i_cmd_mask,
   output logic        o_rsp_valid,
   input  logic        i_rsp_ready,
   output logic [31:0] o_rsp_data,
   output logic [1:0]  o_rsp_status,
   output logic [7:0]  o_bus_addr,
   output logic [31:0] o_bus_wdata,
   output logic        o_bus_read,
   output logic        o_bus_write,
   input  logic [31:0] i_bus_rdata,
   input  logic        i_bus_ready,
   output logic        o_busy
);
   typedef enum logic [1:0] {IDLE, ACCESS, POLL_WAIT, RESP} state_t;
   localparam logic [15:0] LP_TMO = 16'(TIMEOUT_CYCLES);
   localparam logic [15:0] LP_PMAX = 16'(POLL_MAX);
   localparam logic [15:0] LP_GAP = 16'(POLL_GAP);
   state_t r_state, w_state;
   logic r_cmd_ready, w_cmd_ready, r_rsp_valid, w_rsp_valid, r_bus_read, w_bus_read, r_bus_write, w_bus_write;
   logic [1:0] r_op, w_op, r_rsp_status, w_rsp_status;
   logic [7:0] r_bus_addr, w_bus_addr;
   logic [31:0] r_bus_wdata, w_bus_wdata, r_mask, w_mask, r_rsp_data, w_rsp_data;
   logic [15:0] r_tcnt, w_tcnt, r_pcnt, w_pcnt, r_gcnt, w_gcnt;
   logic [15:0] w_tcnt_inc, w_pcnt_inc, w_gcnt_inc;
   logic w_match;
   assign w_tcnt_inc = (r_tcnt == 16'hFFFF) ? r_tcnt : r_tcnt + 16'd1;
   assign w_pcnt_inc = (r_pcnt == 16'hFFFF) ? r_pcnt : r_pcnt + 16'd1;
   assign w_gcnt_inc = (r_gcnt == 16'hFFFF) ? r_gcnt : r_gcnt + 16'd1;
   // For polls the expected value is held in the bus_wdata register.
   assign w_match = ((i_bus_rdata ^ r_bus_wdata) & r_mask) == 32'd0;
   always_comb begin
      w_state = r_state;
      w_cmd_ready = r_cmd_ready;
      w_rsp_valid = r_rsp_valid;
      w_rsp_data = r_rsp_data;
      w_rsp_status = r_rsp_status;
      w_bus_read = r_bus_read;
      w_bus_write = r_bus_write;
      w_bus_addr = r_bus_addr;
      w_bus_wdata = r_bus_wdata;
      w_op = r_op;
      w_mask = r_mask;
      w_tcnt = r_tcnt;
      w_pcnt = r_pcnt;
      w_gcnt = r_gcnt;
      case (r_state)
         IDLE: if (i_cmd_valid && r_cmd_ready) begin
            w_cmd_ready = 1'b0;
            w_op = i_cmd_op;
            w_bus_addr = i_cmd_addr;
            w_bus_wdata = i_cmd_wdata;
            w_mask = i_cmd_mask;
            w_rsp_data = 32'd0;
            w_rsp_status = 2'b00;
            w_tcnt = 16'd0;
            w_pcnt = 16'd0;
            if (i_cmd_op == 2'b11) begin
               w_state = RESP;
               w_rsp_valid = 1'b1;
               w_rsp_status = 2'b11;
            end else begin
               w_state = ACCESS;
               w_bus_read = i_cmd_op != 2'b01;
               w_bus_write = i_cmd_op == 2'b01;
            end
         end
         ACCESS: if (i_bus_ready) begin
            w_bus_read = 1'b0;
            w_bus_write = 1'b0;
            if (r_op == 2'b01) begin
               w_state = RESP;
               w_rsp_valid = 1'b1;
            end else if (r_op == 2'b00 || w_match) begin
               w_state = RESP;
               w_rsp_valid = 1'b1;
               w_rsp_data = i_bus_rdata;
            end else begin
               w_rsp_data = i_bus_rdata;
               w_pcnt = w_pcnt_inc;
               if (w_pcnt_inc == LP_PMAX) begin
                  w_state = RESP;
                  w_rsp_valid = 1'b1;
                  w_rsp_status = 2'b10;
               end else if (LP_GAP == 16'd0) begin
                  w_bus_read = 1'b1;
                  w_tcnt = 16'd0;
               end else begin
                  w_state = POLL_WAIT;
                  w_gcnt = 16'd0;
               end
            end
         end else begin
            w_tcnt = w_tcnt_inc;
            // rsp_data already holds 0 for read/write, or the last polled value.
            if (w_tcnt_inc >= LP_TMO) begin
               w_state = RESP;
               w_bus_read = 1'b0;
               w_bus_write = 1'b0;
               w_rsp_valid = 1'b1;
               w_rsp_status = 2'b01;
            end
         end
         POLL_WAIT: begin
            w_gcnt = w_gcnt_inc;
            if (w_gcnt_inc >= LP_GAP) begin
               w_state = ACCESS;
               w_bus_read = 1'b1;
               w_tcnt = 16'd0;
            end
         end
         RESP: if (i_rsp_ready) begin
            w_state = IDLE;
            w_rsp_valid = 1'b0;
            w_cmd_ready = 1'b1;
         end
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cmd_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_data <= 32'd0;
         r_rsp_status <= 2'b00;
         r_bus_read <= 1'b0;
         r_bus_write <= 1'b0;
         r_bus_addr <= 8'd0;
         r_bus_wdata <= 32'd0;
         r_op <= 2'b00;
         r_mask <= 32'd0;
         r_tcnt <= 16'd0;
         r_pcnt <= 16'd0;
         r_gcnt <= 16'd0;
      end else begin
         r_state <= w_state;
         r_cmd_ready <= w_cmd_ready;
         r_rsp_valid <= w_rsp_valid;
         r_rsp_data <= w_rsp_data;
         r_rsp_status <= w_rsp_status;
         r_bus_read <= w_bus_read;
         r_bus_write <= w_bus_write;
         r_bus_addr <= w_bus_addr;
         r_bus_wdata <= w_bus_wdata;
         r_op <= w_op;
         r_mask <= w_mask;
         r_tcnt <= w_tcnt;
         r_pcnt <= w_pcnt;
         r_gcnt <= w_gcnt;
      end
   end
   assign o_cmd_ready = r_cmd_ready;
   assign o_rsp_valid = r_rsp_valid;
   assign o_rsp_data = r_rsp_data;
   assign o_rsp_status = r_rsp_status;
   assign o_bus_addr = r_bus_addr;
   assign o_bus_wdata = r_bus_wdata;
   assign o_bus_read = r_bus_read;
   assign o_bus_write = r_bus_write;
   assign o_busy = r_state != IDLE;
endmodule

// File: tb/tb_periph_bus_master.sv
// tb_periph_bus_master: directed vector table plus hand sequences for timeout, backpressure and reset.
module tb_periph_bus_master;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic [1:0]  cmd_op = 2'b00;
   logic [7:0]  cmd_addr = 8'h00;
   logic [31:0] cmd_wdata = 32'h0;
   logic [31:0] cmd_mask = 32'h0;
   logic        rsp_ready = 1'b1;
   logic        bus_ready = 1'b1;
   logic        cmd_ready, rsp_valid, bus_read, bus_write, busy;
   logic [31:0] rsp_data, bus_wdata, bus_rdata;
   logic [1:0]  rsp_status;
   logic [7:0]  bus_addr;
   int total = 0;
   int bad = 0;
   int rd_hi = 0, wr_hi = 0, both = 0, rd_cnt = 0, set_at = -1;
   logic [31:0] ctrl = 32'h0;

   periph_bus_master #(.TIMEOUT_CYCLES(16), .POLL_MAX(8), .POLL_GAP(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_op(cmd_op), .i_cmd_addr(cmd_addr),
      .i_cmd_wdata(cmd_wdata), .i_cmd_mask(cmd_mask),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data), .o_rsp_status(rsp_status),
      .o_bus_addr(bus_addr), .o_bus_wdata(bus_wdata), .o_bus_read(bus_read), .o_bus_write(bus_write),
      .i_bus_rdata(bus_rdata), .i_bus_ready(bus_ready), .o_busy(busy)
   );

   always #5 clk = ~clk;

   // Slave: ID at 0x00, CTRL at 0x08 mirrored as STATUS at 0x04.
   assign bus_rdata = (bus_addr == 8'h00) ? 32'h05B20001 :
                      (bus_addr == 8'h04 || bus_addr == 8'h08) ? ctrl : 32'h0;

   always @(posedge clk) begin
      if (bus_read) rd_hi <= rd_hi + 1;
      if (bus_write) wr_hi <= wr_hi + 1;
      if (bus_read && bus_write) both <= both + 1;
      if (bus_read && bus_ready) begin
         rd_cnt <= rd_cnt + 1;
         if (rd_cnt + 1 == set_at) ctrl <= 32'h1;
      end
      if (bus_write && bus_ready && bus_addr == 8'h08) ctrl <= bus_wdata;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic [1:0]  op;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [31:0] mask;
      logic [31:0] data;
      logic [1:0]  st;
      int          lat;
      int          rd;
      int          wr;
      int          set_after;
   } vec_t;

   task automatic run_cmd(input vec_t v, input int hold, input string tag);
      int r0, w0, n, unstable;
      logic [31:0] d;
      logic [1:0] s;
      r0 = rd_hi;
      w0 = wr_hi;
      set_at = (v.set_after > 0) ? rd_cnt + v.set_after : -1;
      rsp_ready = (hold == 0);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op = v.op;
      cmd_addr = v.addr;
      cmd_wdata = v.wdata;
      cmd_mask = v.mask;
      n = 0;
      while (!cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk({tag, " cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      n = 0;
      while (n < 200) begin
         @(negedge clk);
         n++;
         if (rsp_valid) break;
      end
      chk({tag, " latency"}, n, v.lat);
      chk({tag, " data"}, rsp_data, v.data);
      chk({tag, " status"}, {30'd0, rsp_status}, {30'd0, v.st});
      d = rsp_data;
      s = rsp_status;
      unstable = 0;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (!rsp_valid || rsp_data !== d || rsp_status !== s || cmd_ready) unstable++;
      end
      if (hold > 0) chk({tag, " hold_stable"}, unstable, 0);
      rsp_ready = 1'b1;
      @(negedge clk);
      chk({tag, " rsp_valid_drop"}, {31'd0, rsp_valid}, 32'd0);
      chk({tag, " cmd_ready_back"}, {31'd0, cmd_ready}, 32'd1);
      chk({tag, " read_strobe_cycles"}, rd_hi - r0, v.rd);
      chk({tag, " write_strobe_cycles"}, wr_hi - w0, v.wr);
   endtask

   vec_t tv[8];
   vec_t tmo;

   initial begin
      tv[0] = '{2'b00, 8'h00, 32'h0,        32'h0, 32'h05B20001, 2'b00, 2,  1, 0, 0};
      tv[1] = '{2'b01, 8'h08, 32'h00000003, 32'h0, 32'h0,        2'b00, 2,  0, 1, 0};
      tv[2] = '{2'b00, 8'h04, 32'h0,        32'h0, 32'h00000003, 2'b00, 2,  1, 0, 0};
      tv[3] = '{2'b01, 8'h08, 32'h0,        32'h0, 32'h0,        2'b00, 2,  0, 1, 0};
      tv[4] = '{2'b10, 8'h04, 32'hFFFFFFFF, 32'h0, 32'h0,        2'b00, 2,  1, 0, 0};
      tv[5] = '{2'b11, 8'h00, 32'h0,        32'h0, 32'h0,        2'b11, 1,  0, 0, 0};
      tv[6] = '{2'b10, 8'h04, 32'h1,        32'h1, 32'h0,        2'b10, 37, 8, 0, 0};
      tv[7] = '{2'b10, 8'h04, 32'h1,        32'h1, 32'h00000001, 2'b00, 17, 4, 0, 3};
      tmo   = '{2'b00, 8'h00, 32'h0,        32'h0, 32'h0,        2'b01, 17, 16, 0, 0};
      repeat (2) @(negedge clk);
      chk("reset cmd_ready", {31'd0, cmd_ready}, 32'd1);
      chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("reset rsp_data", rsp_data, 32'd0);
      chk("reset rsp_status", {30'd0, rsp_status}, 32'd0);
      chk("reset strobes", {30'd0, bus_read, bus_write}, 32'd0);
      chk("reset bus_addr", {24'd0, bus_addr}, 32'd0);
      chk("reset busy", {31'd0, busy}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 8; i++) run_cmd(tv[i], 0, $sformatf("vec%0d", i));
      bus_ready = 1'b0;
      run_cmd(tmo, 0, "timeout");
      run_cmd(tmo, 10, "timeout_backpressure");
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op = 2'b00;
      cmd_addr = 8'h00;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_access bus_read", {31'd0, bus_read}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("async_reset bus_read", {31'd0, bus_read}, 32'd0);
      chk("async_reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("async_reset busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      bus_ready = 1'b1;
      @(negedge clk);
      chk("post_reset cmd_ready", {31'd0, cmd_ready}, 32'd1);
      chk("post_reset busy", {31'd0, busy}, 32'd0);
      chk("strobe exclusivity", both, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/periph_bus_master.md
Name: periph_bus_master

Overview:
- Bus initiator that drives the 8-bit-address peripheral register bus (addr/wdata/read/write/rdata/ready) used by the USB controller and sibling peripherals.
- Accepts single commands (read, write, poll-until-match) over a valid/ready command port and returns one response per command over a valid/ready response port.
- Used by the bring-up sequencer and the simulation testbench to script peripheral register traffic without a CPU.

Parameters:
- TIMEOUT_CYCLES, 16, max cycles a strobe is held with ready low before abort; valid range 1..65535
- POLL_MAX, 1024, max reads per poll command before giving up; valid range 1..65535
- POLL_GAP, 4, idle cycles between successive poll reads; valid range 0..255

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high
- cmd_op  in  2  00 read, 01 write, 10 poll, 11 reserved
- cmd_addr  in  8  register address
- cmd_wdata  in  32  write data (write); expected value (poll)
- cmd_mask  in  32  compare mask (poll only)
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid and rsp_ready are both high
- rsp_data  out  32  read data, or last polled value; 0 for write
- rsp_status  out  2  00 OK, 01 bus timeout, 10 poll expired, 11 bad op
- bus_addr  out  8  to slave addr
- bus_wdata  out  32  to slave wdata
- bus_read  out  1  read strobe
- bus_write  out  1  write strobe
- bus_rdata  in  32  slave read data, combinational from bus_addr
- bus_ready  in  1  slave ready
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: clk; reset rst_n, asynchronous, active-low.
- Reset values: state IDLE; cmd_ready=1; rsp_valid=0; rsp_data=0; rsp_status=00; bus_addr=0; bus_wdata=0; bus_read=0; bus_write=0; busy=0; all counters 0.
- Reset asserted mid-operation: strobes drop immediately (async), any pending response is discarded, and the FSM returns to IDLE.
- States: IDLE, ACCESS, POLL_WAIT, RESP.
- cmd_ready is registered and high only in IDLE.
- IDLE, command accepted at edge N:
  - Latch the command fields.
  - op 11: go to RESP with status 11 and rsp_data 0; no bus activity.
  - Otherwise: go to ACCESS, assert bus_read (ops 00 and 10) or bus_write (op 01) in cycle N+1, and clear the timeout counter.
- ACCESS:
  - The strobe is held and bus_addr/bus_wdata are stable until bus_ready is sampled high.
  - On the edge with bus_ready=1: drop the strobe.
  - On that same edge, for a read or poll, capture bus_rdata. For a write, rsp_data=0.
  - If bus_ready is low, increment the timeout counter.
  - When the counter reaches TIMEOUT_CYCLES, drop the strobe and go to RESP with status 01, rsp_data 0 for read/write and the last captured value for poll.
  - Zero-wait slave: strobe is high exactly one cycle (N+1); rsp_valid is high at N+2.
- Poll compare, on the capture edge:
  - Match when (bus_rdata & cmd_mask) == (cmd_wdata & cmd_mask). On match, go to RESP with status 00 and rsp_data = bus_rdata.
  - On mismatch, increment the poll count. If poll count == POLL_MAX, go to RESP with status 10 and rsp_data = last value.
  - Otherwise go to POLL_WAIT for POLL_GAP cycles, then return to ACCESS; POLL_GAP=0 means go straight back to ACCESS.
  - cmd_mask=0 always matches on the first read.
- RESP:
  - rsp_valid stays high; rsp_data and rsp_status are stable until rsp_valid && rsp_ready.
  - On that handshake: go to IDLE and raise cmd_ready on the next cycle.
  - Minimum command-to-command spacing is therefore 3 cycles.
- Exclusivity: bus_read and bus_write are never high together; no strobe is ever asserted outside ACCESS.
- Counters are 16-bit and saturate; they never wrap.

Test Plan:
- Read ID: slave with ready tied 1; read addr 0x00 -> one-cycle bus_read; rsp_data=0x05B20001, status 00; rsp_valid exactly 2 cycles after accept.
- Write then read: write 0x08 <- 0x00000003, then read 0x04 -> write strobe 1 cycle, write rsp_data 0; read returns 0x00000003.
- Poll success: slave STATUS bit0 set by a write after 3 poll reads, poll 0x04 mask 0x1 expect 0x1 -> exactly 4 reads separated by 4 idle cycles; status 00, rsp_data=0x00000001.
- Poll expiry: POLL_MAX=8, STATUS stays 0 -> exactly 8 reads; status 10, rsp_data 0.
- Timeout and backpressure: bus_ready held 0 -> strobe held 16 cycles then dropped, status 01. Repeat with rsp_ready low for 10 cycles -> response stable throughout; cmd_ready low until the handshake.
- Bad op and reset: op 11 -> status 11, no strobe. rst_n pulsed low mid-ACCESS -> bus_read drops asynchronously, rsp_valid=0, cmd_ready=1 after reset is released.
